matrix_loader: RTL

//  Upstream feeder for the matrix coprocessor. Accepts matrix A then matrix B as a stream of signed 8-bit elements over a valid/ready handshake.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_index_counter.sv | 41 ++++
 rtl/matrix_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix coprocessor memory map and the loader FSM.
package matrix_pkg;
  localparam int DIM_MAX     = 5;
  localparam int ELEMS       = DIM_MAX * DIM_MAX;
  localparam int DATA_W      = 8;
  // Coprocessor results start right after the 25 operand words.
  localparam int RESULT_BASE = ELEMS;

  localparam logic [1:0] SZ_2X2 = 2'b00;
  localparam logic [1:0] SZ_3X3 = 2'b01;
  localparam logic [1:0] SZ_4X4 = 2'b10;
  localparam logic [1:0] SZ_5X5 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV_A = 3'd1,
    ST_RECV_B = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [2:0] size_to_n(input logic [1:0] code);
    return {1'b0, code} + 3'd2;
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker over an NxN sub-block of the fixed DIM_MAX-wide row-major layout.
module matrix_index_counter #(
  parameter int DIM_MAX = matrix_pkg::DIM_MAX,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_adv,
  input  logic [2:0]       i_n,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);
  logic [2:0] r_row;
  logic [2:0] r_col;
  logic       w_col_end;
  logic       w_row_end;

  assign w_col_end = (r_col == i_n - 3'd1);
  assign w_row_end = (r_row == i_n - 3'd1);
  assign o_last    = w_col_end && w_row_end;
  assign o_idx     = IDX_W'(r_row) * IDX_W'(DIM_MAX) + IDX_W'(r_col);

  // Wraps back to (0,0) after the last element, ready for the next matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? 3'd0 : r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end
endmodule

// File: rtl/matrix_loader.sv
// Streams matrix A then B into padded 5x5 buffers and writes 25 packed {B,A} words to memory.
module matrix_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int DIM_MAX   = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               matrix_size,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [2*DATA_W-1:0]      mem_data,
  output logic                     mem_we,
  output logic                     busy,
  output logic                     load_done
);
  import matrix_pkg::*;

  localparam int NEL   = DIM_MAX * DIM_MAX;
  localparam int IDX_W = $clog2(NEL + 1);

  state_t                    r_state;
  logic [2:0]                r_n;
  logic signed [DATA_W-1:0]  r_buf_a [NEL];
  logic signed [DATA_W-1:0]  r_buf_b [NEL];
  logic [IDX_W-1:0]          r_wi;
  logic                      r_in_ready;
  logic                      r_mem_we;
  logic                      r_busy;
  logic                      r_load_done;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic [2*DATA_W-1:0]       r_mem_data;

  logic                      w_start;
  logic                      w_xfer;
  logic                      w_last;
  logic [IDX_W-1:0]          w_idx;

  assign w_start = (r_state == ST_IDLE) && start;
  assign w_xfer  = in_valid && r_in_ready;

  matrix_index_counter #(
    .DIM_MAX (DIM_MAX),
    .IDX_W   (IDX_W)
  ) u_idx (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (w_start),
    .i_adv   (w_xfer),
    .i_n     (r_n),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_wi        <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      for (int i = 0; i < NEL; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n        <= size_to_n(matrix_size);
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ST_RECV_A;
            for (int i = 0; i < NEL; i++) begin
              r_buf_a[i] <= '0;
              r_buf_b[i] <= '0;
            end
          end
        end
        ST_RECV_A: begin
          if (w_xfer) begin
            r_buf_a[w_idx] <= in_data;
            if (w_last) r_state <= ST_RECV_B;
          end
        end
        ST_RECV_B: begin
          if (w_xfer) begin
            r_buf_b[w_idx] <= in_data;
            // Word 0 is issued on the same edge; the final B element never lands at index 0.
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_mem_we   <= 1'b1;
              r_mem_addr <= ADDR_W'(BASE_ADDR);
              r_mem_data <= {r_buf_b[0], r_buf_a[0]};
              r_wi       <= IDX_W'(1);
              r_state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (r_wi == IDX_W'(NEL)) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_wi);
            r_mem_data <= {r_buf_b[r_wi], r_buf_a[r_wi]};
            r_wi       <= r_wi + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;
  assign load_done = r_load_done;
endmodule
